// File: rtl/tensor_ram_writer.sv
// -----------------------------------------------------------------------------
// tensor_ram_writer
//
// Packs a raster-ordered stream of int8 output activations (row, col, channel;
// channel innermost) into 128-bit tensor_ram words in channel-last layout, and
// issues one strobed word write per 16 bytes, plus a partial write for the
// final word of a layer. The byte placement mirrors the layer patch reader:
// byte offset 0 lands in ram_din3[31:24] and offset 15 in ram_din0[7:0].
//
// Optional feature: define TENSOR_WRITER_RELU_EN to clamp negative activations
// to 0x00 before packing. Clamped bytes still count and are still strobed.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a layer (only honoured in IDLE); latches config
//   img_width/height    output tensor W / H
//   num_channels        output channels C
//   base_word_addr      destination base word address
//   in_valid/in_data    activation byte stream
//   in_ready            byte accepted when in_valid && in_ready
//   ram_we              single-cycle word write strobe
//   ram_addr            write word address
//   ram_din0..3         write data (din3 holds byte offsets 0..3)
//   ram_wstrb           byte strobe, bit i = byte offset i
//   busy                high outside IDLE
//   layer_done          one-cycle pulse at end of layer
//   cur_row/col/channel position of the next expected byte
// -----------------------------------------------------------------------------
module tensor_ram_writer #(
  parameter int MAX_IMG_W    = 64,
  parameter int MAX_IMG_H    = 64,
  parameter int MAX_CHANNELS = 64,
  parameter int ADDR_W       = $clog2(MAX_IMG_W * MAX_IMG_H * MAX_CHANNELS / 16)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(MAX_IMG_W+1)-1:0]    img_width,
  input  logic [$clog2(MAX_IMG_H+1)-1:0]    img_height,
  input  logic [$clog2(MAX_CHANNELS+1)-1:0] num_channels,
  input  logic [ADDR_W-1:0]                 base_word_addr,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  output logic                              in_ready,
  output logic                              ram_we,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [31:0]                       ram_din0,
  output logic [31:0]                       ram_din1,
  output logic [31:0]                       ram_din2,
  output logic [31:0]                       ram_din3,
  output logic [15:0]                       ram_wstrb,
  output logic                              busy,
  output logic                              layer_done,
  output logic [$clog2(MAX_IMG_H+1)-1:0]    cur_row,
  output logic [$clog2(MAX_IMG_W+1)-1:0]    cur_col,
  output logic [$clog2(MAX_CHANNELS+1)-1:0] cur_channel
);

  localparam int WW = $clog2(MAX_IMG_W + 1);
  localparam int HW = $clog2(MAX_IMG_H + 1);
  localparam int CW = $clog2(MAX_CHANNELS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t         state_q;

  // Latched layer configuration.
  logic [WW-1:0]     w_q;
  logic [HW-1:0]     h_q;
  logic [CW-1:0]     c_q;
  logic [ADDR_W-1:0] base_q;

  // Position of the next expected byte.
  logic [HW-1:0]     row_q;
  logic [WW-1:0]     col_q;
  logic [CW-1:0]     ch_q;

  // Bytes arrive strictly in element-index order, so the byte offset within
  // the word (e[3:0]) is a 4-bit running count and the word index (e>>4) is
  // the number of words already flushed. This avoids the (row*W+col)*C+ch
  // multiply while producing identical offsets and addresses.
  logic [3:0]        off_q;
  logic [ADDR_W-1:0] word_q;

  logic [127:0]      buf_q;
  logic [15:0]       strb_q;
  logic              last_q;

  // Registered outputs.
  logic              in_ready_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [127:0]      ram_data_q;
  logic [15:0]       ram_wstrb_q;
  logic              busy_q;
  logic              layer_done_q;

  logic [7:0]        byte_in;
  logic [127:0]      buf_d;
  logic [15:0]       strb_d;
  logic              ch_last;
  logic              col_last;
  logic              row_last;
  logic              elem_last;
  logic              handshake;

`ifdef TENSOR_WRITER_RELU_EN
  assign byte_in = in_data[7] ? 8'h00 : in_data;
`else
  assign byte_in = in_data;
`endif

  assign ch_last   = (ch_q  == c_q - CW'(1));
  assign col_last  = (col_q == w_q - WW'(1));
  assign row_last  = (row_q == h_q - HW'(1));
  assign elem_last = row_last && col_last && ch_last;
  assign handshake = in_valid && in_ready_q;

  // Buffer/strobe contents including the byte being accepted this cycle.
  // Offset o occupies bits [8*(15-o) +: 8]; for a 4-bit o, 15-o == ~o.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    buf_d                     = buf_q;
    strb_d                    = strb_q | (16'd1 << off_q);
    buf_d[{~off_q, 3'b000} +: 8] = byte_in;
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pack buffer is an ordinary register bank (not a RAM), so it
      // is reset along with everything else; a mid-layer reset must leave no
      // stale bytes behind.
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      c_q          <= '0;
      base_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ch_q         <= '0;
      off_q        <= '0;
      word_q       <= '0;
      buf_q        <= '0;
      strb_q       <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wstrb_q  <= '0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q    <= img_width;
            h_q    <= img_height;
            c_q    <= num_channels;
            base_q <= base_word_addr;
            row_q  <= '0;
            col_q  <= '0;
            ch_q   <= '0;
            off_q  <= '0;
            word_q <= '0;
            buf_q  <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
            busy_q <= 1'b1;
            // W*H*C is zero exactly when any factor is zero.
            if (img_width == '0 || img_height == '0 || num_channels == '0) begin
              state_q      <= S_DONE;
              layer_done_q <= 1'b1;
            end else begin
              state_q    <= S_ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (handshake) begin
            buf_q  <= buf_d;
            strb_q <= strb_d;
            off_q  <= off_q + 4'd1;

            if (ch_last) begin
              ch_q <= '0;
              if (col_last) begin
                col_q <= '0;
                row_q <= row_q + HW'(1);
              end else begin
                col_q <= col_q + WW'(1);
              end
            end else begin
              ch_q <= ch_q + CW'(1);
            end

            // Word is complete or the layer ends: present the write in the
            // FLUSH cycle straight from the updated buffer.
            if (off_q == 4'hF || elem_last) begin
              state_q     <= S_FLUSH;
              in_ready_q  <= 1'b0;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= base_q + word_q;
              ram_data_q  <= buf_d;
              ram_wstrb_q <= strb_d;
              last_q      <= elem_last;
            end
          end
        end

        S_FLUSH: begin
          ram_we_q <= 1'b0;
          buf_q    <= '0;
          strb_q   <= '0;
          word_q   <= word_q + ADDR_W'(1);
          if (last_q) begin
            state_q      <= S_DONE;
            layer_done_q <= 1'b1;
          end else begin
            state_q    <= S_ACCEPT;
            in_ready_q <= 1'b1;
          end
        end

        S_DONE: begin
          layer_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din3    = ram_data_q[127:96];
  assign ram_din2    = ram_data_q[95:64];
  assign ram_din1    = ram_data_q[63:32];
  assign ram_din0    = ram_data_q[31:0];
  assign ram_wstrb   = ram_wstrb_q;
  assign busy        = busy_q;
  assign layer_done  = layer_done_q;
  assign cur_row     = row_q;
  assign cur_col     = col_q;
  assign cur_channel = ch_q;

endmodule

// File: tb/tb_tensor_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_tensor_ram_writer
//
// Directed bench for tensor_ram_writer. Inputs are driven 1 ns after the
// falling edge; a monitor logs writes, accepted bytes, FLUSH stalls and
// layer_done pulses 2 ns after the falling edge, so every sample sits well
// away from the rising edge. Expected words are hand-computed constants.
// Define TENSOR_WRITER_RELU_EN for both bench and RTL to cover the clamp.
// -----------------------------------------------------------------------------
module tb_tensor_ram_writer;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [6:0]        img_width;
  logic [6:0]        img_height;
  logic [6:0]        num_channels;
  logic [ADDR_W-1:0] base_word_addr;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din0, ram_din1, ram_din2, ram_din3;
  logic [15:0]       ram_wstrb;
  logic              busy;
  logic              layer_done;
  logic [6:0]        cur_row, cur_col, cur_channel;

  tensor_ram_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .img_width     (img_width),
    .img_height    (img_height),
    .num_channels  (num_channels),
    .base_word_addr(base_word_addr),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din0      (ram_din0),
    .ram_din1      (ram_din1),
    .ram_din2      (ram_din2),
    .ram_din3      (ram_din3),
    .ram_wstrb     (ram_wstrb),
    .busy          (busy),
    .layer_done    (layer_done),
    .cur_row       (cur_row),
    .cur_col       (cur_col),
    .cur_channel   (cur_channel)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor log (written only by the monitor process).
  logic [ADDR_W-1:0] wr_addr[$];
  logic [127:0]      wr_data[$];
  logic [15:0]       wr_strb[$];
  logic [7:0]        acc_data[$];
  int                cyc       = 0;
  int                wr_cyc    = -1;
  int                done_cyc  = -1;
  int                done_cnt  = 0;
  int                stall_cnt = 0;

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (reset === 1'b0) begin
      if (ram_we === 1'b1) begin
        wr_addr.push_back(ram_addr);
        wr_data.push_back({ram_din3, ram_din2, ram_din1, ram_din0});
        wr_strb.push_back(ram_wstrb);
        wr_cyc = cyc;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) acc_data.push_back(in_data);
      if (busy === 1'b1 && in_ready === 1'b0 && layer_done === 1'b0) stall_cnt++;
      if (layer_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_layer(input int w, input int h, input int c, input int base);
    img_width      = 7'(w);
    img_height     = 7'(h);
    num_channels   = 7'(c);
    base_word_addr = ADDR_W'(base);
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // Offers bytes d0, d0+1, ... until n are accepted; leaves in_valid = keep.
  task automatic stream(input string tag, input int n, input logic [7:0] d0, input logic keep);
    int sent = 0;
    int g    = 0;
    while (sent < n && g < 200) begin
      in_valid = 1'b1;
      in_data  = 8'(d0 + sent);
      if (in_ready === 1'b1) sent++;
      tick();
      g++;
    end
    in_valid = keep;
    check({tag, "_sent"}, 128'(sent), 128'(n));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (layer_done !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    check({tag, "_done_seen"}, {127'b0, layer_done}, 128'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [ADDR_W-1:0] addr,
                             input logic [127:0] data, input logic [15:0] strb);
    logic [ADDR_W-1:0] a;
    logic [127:0]      d;
    logic [15:0]       s;
    a = 'x; d = 'x; s = 'x;
    if (idx < wr_addr.size()) begin
      a = wr_addr[idx];
      d = wr_data[idx];
      s = wr_strb[idx];
    end
    check({tag, "_addr"}, 128'(a), 128'(addr));
    check({tag, "_data"}, d, data);
    check({tag, "_wstrb"}, 128'(s), 128'(strb));
  endtask

  int wr0, acc0, st0, dn0, bad;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    img_width = '0; img_height = '0; num_channels = '0; base_word_addr = '0;
    tick(); tick(); tick();

    // ---- Reset state ----
    check("rst_ctrl", {124'b0, in_ready, ram_we, busy, layer_done}, 128'd0);
    check("rst_data", {ram_din3, ram_din2, ram_din1, ram_din0}, 128'd0);
    check("rst_misc", {79'b0, ram_addr, ram_wstrb, cur_row, cur_col, cur_channel}, 128'd0);
    reset = 1'b0;
    tick();

    // ---- Test 1: W=4,H=4,C=1, one full word; a start while busy is ignored ----
    wr0 = wr_addr.size();
    dn0 = done_cnt;
    start_layer(4, 4, 1, 0);
    check("t1_busy", {127'b0, busy}, 128'd1);
    img_width = 7'd1; img_height = 7'd1; num_channels = 7'd1; base_word_addr = 14'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    stream("t1", 16, 8'h00, 1'b0);
    wait_done("t1");
    tick();
    check("t1_nwr", 128'(wr_addr.size() - wr0), 128'd1);
    check_write("t1_w0", wr0, 14'd0, 128'h00010203_04050607_08090A0B_0C0D0E0F, 16'hFFFF);
    check("t1_done_after_flush", 128'(done_cyc), 128'(wr_cyc + 1));
    tick(); tick();
    check("t1_done_once", 128'(done_cnt - dn0), 128'd1);
    check("t1_idle", {126'b0, busy, layer_done}, 128'd0);

    // ---- Test 2: W=3,H=1,C=3, single partial word ----
    wr0 = wr_addr.size();
    start_layer(3, 1, 3, 9);
    stream("t2", 9, 8'h10, 1'b0);
    wait_done("t2");
    tick();
    check("t2_nwr", 128'(wr_addr.size() - wr0), 128'd1);
    check_write("t2_w0", wr0, 14'd9, 128'h10111213_14151617_18000000_00000000, 16'h01FF);

    // ---- Test 3: base=5, W=2,H=2,C=5, one full and one partial word ----
    wr0 = wr_addr.size();
    start_layer(2, 2, 5, 5);
    check("t3_pos0", 128'({cur_row, cur_col, cur_channel}), 128'({7'd0, 7'd0, 7'd0}));
    stream("t3a", 4, 8'h00, 1'b0);
    check("t3_pos4", 128'({cur_row, cur_col, cur_channel}), 128'({7'd0, 7'd0, 7'd4}));
    stream("t3b", 1, 8'h04, 1'b0);
    check("t3_pos5", 128'({cur_row, cur_col, cur_channel}), 128'({7'd0, 7'd1, 7'd0}));
    stream("t3c", 15, 8'h05, 1'b0);
    wait_done("t3");
    tick();
    check("t3_nwr", 128'(wr_addr.size() - wr0), 128'd2);
    check_write("t3_w0", wr0, 14'd5, 128'h00010203_04050607_08090A0B_0C0D0E0F, 16'hFFFF);
    check_write("t3_w1", wr0 + 1, 14'd6, 128'h10111213_00000000_00000000_00000000, 16'h000F);

    // ---- Test 4: continuous in_valid over 32 bytes; stalls only in FLUSH ----
    wr0  = wr_addr.size();
    acc0 = acc_data.size();
    st0  = stall_cnt;
    start_layer(4, 4, 2, 32);
    stream("t4", 32, 8'h40, 1'b1);
    wait_done("t4");
    tick(); tick();
    in_valid = 1'b0;
    tick();
    check("t4_accepted", 128'(acc_data.size() - acc0), 128'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (acc0 + i >= acc_data.size() || acc_data[acc0 + i] !== 8'(8'h40 + i)) bad++;
    end
    check("t4_order_errors", 128'(bad), 128'd0);
    check("t4_stalls", 128'(stall_cnt - st0), 128'd2);
    check("t4_nwr", 128'(wr_addr.size() - wr0), 128'd2);
    check_write("t4_w0", wr0, 14'd32, 128'h40414243_44454647_48494A4B_4C4D4E4F, 16'hFFFF);
    check_write("t4_w1", wr0 + 1, 14'd33, 128'h50515253_54555657_58595A5B_5C5D5E5F, 16'hFFFF);

    // ---- Test 5: reset after 7 accepted bytes ----
    wr0 = wr_addr.size();
    start_layer(4, 4, 1, 16);
    stream("t5", 7, 8'h30, 1'b1);
    reset = 1'b1;
    tick();
    check("t5_ctrl", {124'b0, in_ready, ram_we, busy, layer_done}, 128'd0);
    check("t5_data", {ram_din3, ram_din2, ram_din1, ram_din0}, 128'd0);
    check("t5_misc", {79'b0, ram_addr, ram_wstrb, cur_row, cur_col, cur_channel}, 128'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t5_no_write", 128'(wr_addr.size() - wr0), 128'd0);

    // ---- Test 6: sign bit handling, also a normal start after reset ----
    wr0 = wr_addr.size();
    start_layer(1, 1, 2, 48);
    stream("t6", 2, 8'h7F, 1'b0);
    wait_done("t6");
    tick();
    check("t6_nwr", 128'(wr_addr.size() - wr0), 128'd1);
`ifdef TENSOR_WRITER_RELU_EN
    check_write("t6_w0", wr0, 14'd48, 128'h7F000000_00000000_00000000_00000000, 16'h0003);
`else
    check_write("t6_w0", wr0, 14'd48, 128'h7F800000_00000000_00000000_00000000, 16'h0003);
`endif

    // ---- Test 7: num_channels=0, no writes and one done pulse ----
    wr0 = wr_addr.size();
    dn0 = done_cnt;
    start_layer(4, 4, 0, 0);
    wait_done("t7");
    tick(); tick(); tick();
    check("t7_no_write", 128'(wr_addr.size() - wr0), 128'd0);
    check("t7_done_once", 128'(done_cnt - dn0), 128'd1);
    check("t7_idle", {127'b0, busy}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
